// File: rtl/comparador_argmin_pipe.sv
// Pipelined running arg-min over multi-beat lane vectors.
// A registered pairwise tree reduces each accepted beat to its minimum valid
// lane. An accumulator then folds that result into the running global minimum.
// Optional feature macro: COMPARADOR_ARGMIN_IDX_EN.
//   Defined:   lane and beat tags travel with the data and drive idx_out.
//   Undefined: the tag registers are not built and idx_out is tied to 0.
module comparador_argmin_pipe #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_COMPARADOR = 8,
    parameter int BEAT_WIDTH     = 4,
    localparam int STAGES        = $clog2(NUM_COMPARADOR),
    localparam int IDX_WIDTH     = BEAT_WIDTH + STAGES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 iniciar_in,
    input  logic                                 atualizar_in,
    input  logic                                 finalizar_in,
    input  logic [DATA_WIDTH*NUM_COMPARADOR-1:0] data_in,
    input  logic [NUM_COMPARADOR-1:0]            valid_in,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic [IDX_WIDTH-1:0]                 idx_out,
    output logic                                 found_out,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic                                 overflow_out
);

    localparam int N  = NUM_COMPARADOR;
    localparam int DW = DATA_WIDTH;

    // The extra top bit of the beat counter marks "full" (2**BEAT_WIDTH beats taken).
    logic [BEAT_WIDTH:0] cnt;
    logic                cnt_full;
    logic                accept;
    logic [STAGES:1]     vld_pipe;
    logic                pending;
    logic                fin_req;
    logic                drain_done;
    logic                take;

    // The leaves are combinational. Internal nodes use heap numbering:
    // node 1 is the root, and the children of node k are 2k and 2k+1.
    // Node indices N..2N-1 correspond to lanes 0..N-1.
    logic                leaf_v [N];
    logic [DW-1:0]       leaf_d [N];
    logic                node_v [1:N-1];
    logic [DW-1:0]       node_d [1:N-1];
`ifdef COMPARADOR_ARGMIN_IDX_EN
    logic [STAGES-1:0]     node_l   [1:N-1];
    logic [BEAT_WIDTH-1:0] tag_pipe [1:STAGES];
`endif

    assign cnt_full = cnt[BEAT_WIDTH];
    assign accept   = atualizar_in & ~iniciar_in & ~cnt_full;
    assign busy_out = (|vld_pipe) | pending;

    // A finalize request (new or pending) completes once nothing is in flight.
    assign fin_req    = pending | finalizar_in;
    assign drain_done = fin_req & ~(|vld_pipe) & ~accept;

    // Strict < keeps the earliest beat on ties across beats.
    assign take = node_v[1] & (~found_out | (node_d[1] < data_out));

    // Leaf lanes are masked by accept, so idle cycles inject only invalid lanes.
    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign leaf_v[i] = valid_in[i] & accept;
        assign leaf_d[i] = data_in[DW*i +: DW];
    end

    for (genvar k = 1; k < N; k++) begin : g_node
        logic          lv, rv;
        logic [DW-1:0] ld, rd;
        logic          take_l;
`ifdef COMPARADOR_ARGMIN_IDX_EN
        logic [STAGES-1:0] ll, rl;
`endif
        if (2*k >= N) begin : g_from_leaf
            assign lv = leaf_v[2*k-N];
            assign rv = leaf_v[2*k+1-N];
            assign ld = leaf_d[2*k-N];
            assign rd = leaf_d[2*k+1-N];
`ifdef COMPARADOR_ARGMIN_IDX_EN
            assign ll = STAGES'(2*k-N);
            assign rl = STAGES'(2*k+1-N);
`endif
        end else begin : g_from_node
            assign lv = node_v[2*k];
            assign rv = node_v[2*k+1];
            assign ld = node_d[2*k];
            assign rd = node_d[2*k+1];
`ifdef COMPARADOR_ARGMIN_IDX_EN
            assign ll = node_l[2*k];
            assign rl = node_l[2*k+1];
`endif
        end

        // The left child covers the lower lanes, so it wins ties. An invalid child never wins.
        assign take_l = lv & (~rv | (ld <= rd));

        // Register one compare node. iniciar_in flushes any beat still in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                node_v[k] <= 1'b0;
                node_d[k] <= '1;
`ifdef COMPARADOR_ARGMIN_IDX_EN
                node_l[k] <= '0;
`endif
            end else if (iniciar_in) begin
                node_v[k] <= 1'b0;
            end else begin
                node_v[k] <= lv | rv;
                node_d[k] <= take_l ? ld : rd;
`ifdef COMPARADOR_ARGMIN_IDX_EN
                node_l[k] <= take_l ? ll : rl;
`endif
            end
        end
    end

    // Beat bookkeeping, drain/done tracking and the global min accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            vld_pipe     <= '0;
            pending      <= 1'b0;
            done_out     <= 1'b0;
            overflow_out <= 1'b0;
            found_out    <= 1'b0;
            data_out     <= '1;
`ifdef COMPARADOR_ARGMIN_IDX_EN
            idx_out      <= '0;
            for (int s = 1; s <= STAGES; s++) tag_pipe[s] <= '0;
`endif
        end else if (iniciar_in) begin
            cnt          <= '0;
            vld_pipe     <= '0;
            pending      <= 1'b0;
            done_out     <= 1'b0;
            overflow_out <= 1'b0;
            found_out    <= 1'b0;
            data_out     <= '1;
`ifdef COMPARADOR_ARGMIN_IDX_EN
            idx_out      <= '0;
`endif
        end else begin
            if (accept) cnt <= cnt + (BEAT_WIDTH+1)'(1);
            if (atualizar_in & cnt_full) overflow_out <= 1'b1;
            vld_pipe[1] <= accept;
            for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
            pending  <= fin_req & ~drain_done;
            done_out <= drain_done;
`ifdef COMPARADOR_ARGMIN_IDX_EN
            tag_pipe[1] <= cnt[BEAT_WIDTH-1:0];
            for (int s = 2; s <= STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
`endif
            if (take) begin
                data_out  <= node_d[1];
                found_out <= 1'b1;
`ifdef COMPARADOR_ARGMIN_IDX_EN
                idx_out   <= {tag_pipe[STAGES], node_l[1]};
`endif
            end
        end
    end

`ifndef COMPARADOR_ARGMIN_IDX_EN
    assign idx_out = '0;
`endif

endmodule
